// File: rtl/cdb_arbiter.sv
// Multi-source Common Data Bus arbiter: per-source result FIFOs feeding one registered
// broadcast lane, with round-robin or fixed-priority grant and a mispredict flush.
module cdb_arbiter #(
    parameter int unsigned N_SRC    = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [N_SRC*TAG_W-1:0]     src_tag,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(N_SRC)-1:0]   cdb_src,
    output logic                       idle
);

    localparam int unsigned SRC_W = $clog2(N_SRC);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]  tag_mem_q  [N_SRC][DEPTH];
    logic [DATA_W-1:0] data_mem_q [N_SRC][DEPTH];

    logic [PTR_W-1:0] wr_ptr_q [N_SRC];
    logic [PTR_W-1:0] wr_ptr_d [N_SRC];
    logic [PTR_W-1:0] rd_ptr_q [N_SRC];
    logic [PTR_W-1:0] rd_ptr_d [N_SRC];
    logic [CNT_W-1:0] count_q  [N_SRC];
    logic [CNT_W-1:0] count_d  [N_SRC];

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic [N_SRC-1:0]  req_c;
    logic [N_SRC-1:0]  push_c;
    logic [N_SRC-1:0]  pop_c;
    logic              lo_found_c, hi_found_c;
    logic [SRC_W-1:0]  lo_idx_c, hi_idx_c;
    logic              grant_valid_c;
    logic [SRC_W-1:0]  grant_idx_c;

    // Ready depends only on registered occupancy; a pop this edge is not passed through.
    always_comb begin
        src_ready = '0;
        req_c     = '0;
        push_c    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_ready[i] = (count_q[i] < CNT_W'(DEPTH)) && !flush && !rst;
            req_c[i]     = (count_q[i] != '0);
            push_c[i]    = src_valid[i] && src_ready[i];
        end
    end

    // lo_* is the lowest requester; hi_* the lowest requester at or above rr_ptr.
    always_comb begin
        lo_found_c = 1'b0;
        hi_found_c = 1'b0;
        lo_idx_c   = '0;
        hi_idx_c   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req_c[i] && !lo_found_c) begin
                lo_found_c = 1'b1;
                lo_idx_c   = SRC_W'(i);
            end
            if (req_c[i] && !hi_found_c && (32'(i) >= 32'(rr_ptr_q))) begin
                hi_found_c = 1'b1;
                hi_idx_c   = SRC_W'(i);
            end
        end
    end

    always_comb begin
        grant_valid_c = lo_found_c;
        if ((ARB_MODE == 0) && hi_found_c) begin
            grant_idx_c = hi_idx_c;
        end else begin
            grant_idx_c = lo_idx_c;
        end
        pop_c = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pop_c[i] = grant_valid_c && (grant_idx_c == SRC_W'(i));
        end
    end

    // Next state: flush wipes everything and overrides any push or grant this edge.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            rr_ptr_d = '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push_c[i]) begin
                    wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop_c[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                end
                count_d[i] = count_q[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
            end
            if (grant_valid_c) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = tag_mem_q[grant_idx_c][rd_ptr_q[grant_idx_c]];
                cdb_data_d  = data_mem_q[grant_idx_c][rd_ptr_q[grant_idx_c]];
                cdb_src_d   = grant_idx_c;
                if (grant_idx_c == SRC_W'(N_SRC - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx_c + SRC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Payload storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push_c[i]) begin
                tag_mem_q[i][wr_ptr_q[i]]  <= src_tag[i*TAG_W +: TAG_W];
                data_mem_q[i][wr_ptr_q[i]] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        idle = !cdb_valid_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (count_q[i] != '0) begin
                idle = 1'b0;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule
